max7219_rx: RTL and testbench

// - MAX7219-compatible SPI target. Receives the 16-bit frames our SPI display driver sends and decodes them into
//   the MAX7219 register set. Multiplexes the result onto an 8-digit common-cathode 7-seg display.
// - Use: drive on-board displays directly, or as a loop-back responder for the driver on the same FPGA.

---
 rtl/max7219_pkg.sv | 50 +++++
 rtl/max7219_rx_spi_frame_rx.sv | 109 ++++++++++
 rtl/max7219_rx.sv | 130 +++++++++++++
 tb/tb_max7219_rx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, frame sizing and code-B font for the max7219_rx target.
package max7219_pkg;

    localparam int unsigned FRAME_W    = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SUB_SLOTS  = 16;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum bit [3:0] {
        NOOP       = 4'h0,
        DIG0       = 4'h1,
        DIG1       = 4'h2,
        DIG2       = 4'h3,
        DIG3       = 4'h4,
        DIG4       = 4'h5,
        DIG5       = 4'h6,
        DIG6       = 4'h7,
        DIG7       = 4'h8,
        DECODE     = 4'h9,
        INTENSITY  = 4'hA,
        SCAN_LIMIT = 4'hB,
        SHUTDOWN   = 4'hC,
        DISP_TEST  = 4'hF
    } reg_addr_e;

    // Code-B font, bit 6 = segment A ... bit 0 = segment G.
    function automatic bit [6:0] code_b(input bit [3:0] val);
        case (val)
            4'h0:    return 7'h7E;
            4'h1:    return 7'h30;
            4'h2:    return 7'h6D;
            4'h3:    return 7'h79;
            4'h4:    return 7'h33;
            4'h5:    return 7'h5B;
            4'h6:    return 7'h5F;
            4'h7:    return 7'h70;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7B;
            4'hA:    return 7'h01;
            4'hB:    return 7'h4F;
            4'hC:    return 7'h37;
            4'hD:    return 7'h0E;
            4'hE:    return 7'h67;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/max7219_rx_spi_frame_rx.sv
// SPI mode-0 frame receiver: input synchronizers, edge detect, shift register and frame latch.
// Optional daisy-chain DOUT is enabled with MAX7219_DOUT_EN.
module spi_frame_rx
    import max7219_pkg::*;
#(
    parameter int unsigned SYNC_FF = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_sclk,
    input  logic               i_mosi,
    input  logic               i_ss,
    output logic               o_miso,
    output logic               o_frame_stb,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_err
);

    logic [SYNC_FF-1:0] r_sclk_sync;
    logic [SYNC_FF-1:0] r_mosi_sync;
    logic [SYNC_FF-1:0] r_ss_sync;
    logic               r_sclk_d;
    logic               r_ss_d;
    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_cnt;

    logic w_sclk, w_mosi, w_ss;
    logic w_sclk_rise, w_ss_fall, w_ss_rise;

    // ss chain resets to its idle level so reset release never looks like an ss edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_FF-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_FF-2:0], i_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_FF-2:0], i_ss};
            r_sclk_d    <= r_sclk_sync[SYNC_FF-1];
            r_ss_d      <= r_ss_sync[SYNC_FF-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_FF-1];
    assign w_mosi      = r_mosi_sync[SYNC_FF-1];
    assign w_ss        = r_ss_sync[SYNC_FF-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;
    assign w_ss_rise   = w_ss & ~r_ss_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_ss_fall) begin
            r_cnt <= '0;
        end else if (w_sclk_rise && !w_ss) begin
            r_shreg <= {r_shreg[FRAME_W-2:0], w_mosi};
            if (r_cnt != CNT_W'(FRAME_W)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // A frame is valid only if at least 16 bits arrived; longer frames keep the last 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_frame     <= '0;
            o_frame_stb <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_stb <= 1'b0;
            o_frame_err <= 1'b0;
            if (w_ss_rise) begin
                if (r_cnt == CNT_W'(FRAME_W)) begin
                    o_frame     <= r_shreg;
                    o_frame_stb <= 1'b1;
                end else begin
                    o_frame_err <= 1'b1;
                end
            end
        end
    end

`ifdef MAX7219_DOUT_EN
    logic w_sclk_fall;
    logic r_miso;

    assign w_sclk_fall = ~w_sclk & r_sclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso <= 1'b0;
        end else if (w_ss) begin
            r_miso <= 1'b0;
        end else if (w_sclk_fall) begin
            r_miso <= r_shreg[FRAME_W-1];
        end
    end

    assign o_miso = r_miso;
`else
    assign o_miso = 1'b0;
`endif

endmodule

// File: rtl/max7219_rx.sv
// MAX7219-compatible SPI target: register file, digit scan and intensity PWM for an 8-digit display.
// Define MAX7219_DOUT_EN to drive spi_miso as the 16-clock daisy-chain output.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int unsigned PWM_STEP = 64,
    parameter int unsigned SYNC_FF  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_sclk,
    input  logic               spi_mosi,
    input  logic               spi_ss,
    output logic               spi_miso,
    output logic [7:0]         seg,
    output logic [7:0]         dig_n,
    output logic               frame_stb,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_err
);

    localparam int unsigned SUB_W = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PWM_STEP - 1);

    logic [7:0] r_digit [NUM_DIGITS];
    logic [7:0] r_decode;
    logic [3:0] r_intensity;
    logic [2:0] r_scan_limit;
    logic       r_shutdown;
    logic       r_test;

    logic [SUB_W-1:0] r_sub_cnt;
    logic [3:0]       r_sub_slot;
    logic [2:0]       r_index;

    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic       w_run;
    logic [2:0] w_limit;
    logic [7:0] w_cur;
    logic [7:0] w_digit_seg;
    logic       w_lit;
    logic [7:0] w_dig_sel;

    spi_frame_rx #(
        .SYNC_FF(SYNC_FF)
    ) u_spi_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sclk     (spi_sclk),
        .i_mosi     (spi_mosi),
        .i_ss       (spi_ss),
        .o_miso     (spi_miso),
        .o_frame_stb(frame_stb),
        .o_frame    (frame),
        .o_frame_err(frame_err)
    );

    assign w_addr = frame[11:8];
    assign w_data = frame[7:0];

    // Register file: written in the cycle frame_stb is high, visible the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= '0;
            end
            r_decode     <= '0;
            r_intensity  <= '0;
            r_scan_limit <= '0;
            r_shutdown   <= 1'b0;
            r_test       <= 1'b0;
        end else if (frame_stb) begin
            case (reg_addr_e'(w_addr))
                DIG0, DIG1, DIG2, DIG3,
                DIG4, DIG5, DIG6, DIG7: r_digit[3'(w_addr - 4'd1)] <= w_data;
                DECODE:                 r_decode     <= w_data;
                INTENSITY:              r_intensity  <= w_data[3:0];
                SCAN_LIMIT:             r_scan_limit <= w_data[2:0];
                SHUTDOWN:               r_shutdown   <= w_data[0];
                DISP_TEST:              r_test       <= w_data[0];
                default:                ;
            endcase
        end
    end

    assign w_run   = r_test | r_shutdown;
    assign w_limit = r_test ? 3'd7 : r_scan_limit;

    // Scan counters; an index above a freshly lowered limit wraps at the next slot boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub_cnt  <= '0;
            r_sub_slot <= '0;
            r_index    <= '0;
        end else if (w_run) begin
            if (r_sub_cnt == SUB_LAST) begin
                r_sub_cnt  <= '0;
                r_sub_slot <= r_sub_slot + 4'd1;
                if (r_sub_slot == 4'(SUB_SLOTS - 1)) begin
                    r_index <= (r_index >= w_limit) ? 3'd0 : r_index + 3'd1;
                end
            end else begin
                r_sub_cnt <= r_sub_cnt + SUB_W'(1);
            end
        end
    end

    assign w_cur       = r_digit[r_index];
    assign w_digit_seg = r_decode[r_index] ? {w_cur[7], code_b(w_cur[3:0])} : w_cur;
    assign w_lit       = (r_sub_slot <= r_intensity);
    assign w_dig_sel   = ~(8'd1 << r_index);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= SEG_BLANK;
            dig_n <= 8'hFF;
        end else if (r_test) begin
            seg   <= 8'hFF;
            dig_n <= w_dig_sel;
        end else if (r_shutdown) begin
            seg   <= w_lit ? w_digit_seg : SEG_BLANK;
            dig_n <= w_dig_sel;
        end else begin
            seg   <= SEG_BLANK;
            dig_n <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// Self-checking bench for max7219_rx: SPI frames driven by the bench, display statistics
// over whole scan periods compared with a register-level model of the display.
module tb_max7219_rx;

    localparam int PWM  = 8;
    localparam int SLOT = 16 * PWM;
    localparam int HALF = 3;

    localparam logic [6:0] CODE_B [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00
    };

    logic        clk;
    logic        rst_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_ss;
    logic        spi_miso;
    logic [7:0]  seg;
    logic [7:0]  dig_n;
    logic        frame_stb;
    logic [15:0] frame;
    logic        frame_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_digit [8];
    logic [7:0]  m_decode;
    logic [3:0]  m_intensity;
    logic [2:0]  m_limit;
    logic        m_shutdown;
    logic        m_test;
    logic [15:0] m_frame;

    max7219_rx #(
        .PWM_STEP(PWM),
        .SYNC_FF (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_ss   (spi_ss),
        .spi_miso (spi_miso),
        .seg      (seg),
        .dig_n    (dig_n),
        .frame_stb(frame_stb),
        .frame    (frame),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode    = 8'h00;
        m_intensity = 4'h0;
        m_limit     = 3'd0;
        m_shutdown  = 1'b0;
        m_test      = 1'b0;
        m_frame     = 16'h0000;
    endtask

    task automatic model_write(input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
        else if (a == 9)      m_decode    = w[7:0];
        else if (a == 10)     m_intensity = w[3:0];
        else if (a == 11)     m_limit     = w[2:0];
        else if (a == 12)     m_shutdown  = w[0];
        else if (a == 15)     m_test      = w[0];
    endtask

    function automatic logic [7:0] exp_seg(input int i);
        logic [7:0] d;
        d = m_digit[i];
        if (m_decode[i]) return {d[7], CODE_B[d[3:0]]};
        return d;
    endfunction

    // Send the low n bits of 'bits' MSB first, then check latch / error behaviour.
    task automatic send_bits(input logic [31:0] bits, input int n);
        bit seen_stb, seen_err, miso_ok;
        seen_stb = 0;
        seen_err = 0;
        miso_ok  = 1;
        spi_ss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            repeat (HALF) @(negedge clk);
`ifdef MAX7219_DOUT_EN
            if (i < n - 16 && spi_miso !== bits[i+16]) miso_ok = 0;
`else
            if (spi_miso !== 1'b0) miso_ok = 0;
`endif
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (frame_stb) seen_stb = 1;
            if (frame_err) seen_err = 1;
        end
        if (n >= 16) begin
            m_frame = bits[15:0];
            model_write(m_frame);
        end
        check_eq($sformatf("stb_%0h_n%0d", bits, n), 32'(seen_stb), 32'(n >= 16));
        check_eq($sformatf("err_%0h_n%0d", bits, n), 32'(seen_err), 32'(n < 16));
        check_eq($sformatf("frame_%0h_n%0d", bits, n), 32'(frame), 32'(m_frame));
        check_eq($sformatf("miso_%0h_n%0d", bits, n), 32'(miso_ok), 32'd1);
    endtask

    task automatic send16(input logic [15:0] w);
        send_bits(32'(w), 16);
    endtask

    // Observe one full scan period and compare per-digit on-time and lit-time with the model.
    task automatic measure(input string tag);
        int lim, duty, period, zeros, z;
        int en [8];
        int lit [8];
        int bad_dig, bad_val, dark_bad;
        logic [7:0] ev [8];
        bit dark;
        dark  = !m_test && !m_shutdown;
        lim   = m_test ? 7 : int'(m_limit);
        duty  = m_test ? 16 : int'(m_intensity) + 1;
        for (int i = 0; i < 8; i++) begin
            ev[i]  = m_test ? 8'hFF : exp_seg(i);
            en[i]  = 0;
            lit[i] = 0;
        end
        bad_dig  = 0;
        bad_val  = 0;
        dark_bad = 0;
        repeat (SLOT + 8) @(negedge clk);
        period = dark ? SLOT : (lim + 1) * SLOT;
        for (int c = 0; c < period; c++) begin
            @(negedge clk);
            if (dark) begin
                if (seg !== 8'h00 || dig_n !== 8'hFF) dark_bad++;
            end else begin
                zeros = 0;
                z     = -1;
                for (int i = 0; i < 8; i++) begin
                    if (dig_n[i] === 1'b0) begin
                        zeros++;
                        z = i;
                    end
                end
                if (zeros != 1 || z > lim) bad_dig++;
                else begin
                    en[z]++;
                    if (seg !== 8'h00) begin
                        lit[z]++;
                        if (seg !== ev[z]) bad_val++;
                    end
                end
            end
        end
        if (dark) begin
            check_eq({tag, "_dark"}, 32'(dark_bad), 32'd0);
        end else begin
            check_eq({tag, "_bad_dig"}, 32'(bad_dig), 32'd0);
            check_eq({tag, "_bad_val"}, 32'(bad_val), 32'd0);
            for (int i = 0; i < 8; i++) begin
                check_eq($sformatf("%s_en%0d", tag, i), 32'(en[i]), 32'((i <= lim) ? SLOT : 0));
                check_eq($sformatf("%s_lit%0d", tag, i), 32'(lit[i]),
                         32'((i <= lim && ev[i] != 8'h00) ? duty * PWM : 0));
            end
        end
    endtask

    initial begin
        bit found;
        logic [31:0] bits;
        logic [3:0]  addr;
        logic [7:0]  data;
        int kind, n;

        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_ss   = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check_eq("rst_seg", 32'(seg), 32'h00);
        check_eq("rst_dig_n", 32'(dig_n), 32'hFF);
        check_eq("rst_frame", 32'(frame), 32'h0000);
        check_eq("rst_stb", 32'(frame_stb), 32'd0);
        check_eq("rst_err", 32'(frame_err), 32'd0);
        check_eq("rst_miso", 32'(spi_miso), 32'd0);

        // Digit 1, raw data, intensity 0.
        send16(16'h0C01);
        send16(16'h0105);
        measure("d1_raw");
        found = 0;
        for (int k = 0; k < 4 * SLOT && !found; k++) begin
            @(negedge clk);
            if (seg !== 8'h00) found = 1;
        end
        check_eq("d1_lit_found", 32'(found), 32'd1);
        check_eq("d1_seg", 32'(seg), 32'h05);
        check_eq("d1_dig_n", 32'(dig_n), 32'hFE);

        // Code-B decode, including DP passthrough on the '-' glyph.
        send16(16'h09FF);
        send16(16'h0B07);
        send16(16'h0307);
        measure("decode7");
        send16(16'h038A);
        measure("decodeA");

        send16(16'h0B02);
        measure("lim2");

        // Lowering the limit below the current index wraps to digit 1 at the next slot.
        send16(16'h0B07);
        found = 0;
        for (int k = 0; k < 16 * SLOT && !found; k++) begin
            @(negedge clk);
            if (dig_n !== 8'hF7) found = 1;
        end
        found = 0;
        for (int k = 0; k < 16 * SLOT && !found; k++) begin
            @(negedge clk);
            if (dig_n === 8'hF7) found = 1;
        end
        check_eq("wrap_found_idx3", 32'(found), 32'd1);
        send16(16'h0B01);
        found = 0;
        for (int k = 0; k < 2 * SLOT && !found; k++) begin
            @(negedge clk);
            if (dig_n !== 8'hF7) found = 1;
        end
        check_eq("wrap_left_idx3", 32'(found), 32'd1);
        check_eq("wrap_next_dig_n", 32'(dig_n), 32'hFE);
        measure("lim1");

        send16(16'h0A03);
        measure("int3");
        send16(16'h0A0F);
        measure("intF");

        // Short frame rejected; long frame keeps its last 16 bits.
        send_bits(32'h0000_00A0, 12);
        measure("short");
        send_bits(32'h000A_0A05, 20);
        measure("long");

        send16(16'h0C00);
        measure("shutdown");
        send16(16'h0F01);
        measure("test_in_sd");
        send16(16'h0F00);
        measure("test_off");
        send16(16'h0C01);

        for (int r = 0; r < 10; r++) begin
            for (int f = 0; f < 5; f++) begin
                kind = int'($urandom_range(0, 9));
                addr = 4'($urandom_range(0, 15));
                data = 8'($urandom);
                if (addr == 4'hC) data[0] = ($urandom_range(0, 3) != 0);
                if (addr == 4'hF) data[0] = ($urandom_range(0, 3) == 0);
                bits = $urandom;
                bits[15:0] = {4'($urandom), addr, data};
                if (kind == 0)      n = int'($urandom_range(1, 15));
                else if (kind == 1) n = int'($urandom_range(17, 32));
                else                n = 16;
                send_bits(bits, n);
            end
            measure($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a frame; ss rises in the reset-release cycle.
        spi_ss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            spi_mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_seg", 32'(seg), 32'h00);
        check_eq("midrst_dig_n", 32'(dig_n), 32'hFF);
        check_eq("midrst_frame", 32'(frame), 32'h0000);
        rst_n    = 1'b1;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        model_reset();
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (frame_err || frame_stb) found = 1;
        end
        check_eq("rel_ss_rise_ignored", 32'(found), 32'd0);
        measure("post_rst");
        send16(16'h0C01);
        send16(16'h0B03);
        send16(16'h0A07);
        send16(16'h0442);
        measure("post_rst_run");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
